// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C target with oversampled SCL/SDA, open-drain SDA
// via output-enable, byte-wide write delivery and read-data request handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address byte (7-bit address + R/W)
// ADDR_ACK  | driving ACK for our address, then entering WR or RD
// WR        | shifting in a data byte from the master
// WR_ACK    | driving ACK for a received data byte
// RD        | driving a data byte out on SDA
// RD_ACK    | sampling master ACK/NACK, requesting the next byte on ACK
// IGNORE    | not addressed (or NACKed), waiting for START or STOP
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addr_match
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       first_q, first_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       am_q, am_d;
    logic [7:0] byte_in;

    // Synchronizer chain plus history flop; idle bus level is high.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign start_ev = sda_hist_q & ~sda_s & scl_s;
    assign stop_ev  = ~sda_hist_q & sda_s & scl_s;
    assign byte_in  = {shift_q[6:0], sda_s};

    // State and datapath registers.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            am_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            am_q       <= am_d;
        end
    end

    // Next-state logic; START/STOP override every state, START first.
    // phase_q marks the second half of an ACK slot (ACK driven / master ACK seen).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        first_d    = first_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = rx_first_q;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        am_d       = am_q;
        if (start_ev) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            phase_d = 1'b0;
            oe_d    = 1'b0;
            am_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (stop_ev) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            phase_d = 1'b0;
            oe_d    = 1'b0;
            am_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            phase_d = 1'b0;
                            rw_d    = byte_in[0];
                            state_d = (byte_in[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall && !phase_q) begin
                        oe_d    = 1'b1;
                        am_d    = 1'b1;
                        phase_d = 1'b1;
                    end else if (scl_rise && phase_q && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        if (rw_q) begin
                            shift_d = {tx_data[6:0], 1'b0};
                            oe_d    = ~tx_data[7];
                            cnt_d   = 4'd1;
                            state_d = S_RD;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            first_d = 1'b1;
                            state_d = S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            phase_d    = 1'b0;
                            state_d    = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = S_RD_ACK;
                        end else begin
                            oe_d    = ~shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        shift_d = {tx_data[6:0], 1'b0};
                        oe_d    = ~tx_data[7];
                        cnt_d   = 4'd1;
                        state_d = S_RD;
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    assign sda_oe     = oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_first   = rx_first_q;
    assign tx_req     = tx_req_q;
    assign busy       = busy_q;
    assign addr_match = am_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level master model driving i2c_target, with scoreboard
// queues for written bytes and read bytes.
module tb_i2c_target;
    localparam int Q = 12;

    logic       ref_clk = 1'b0;
    logic       reset;
    logic       scl_in;
    logic       sda_in;
    logic       sda_m;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       addr_match;

    int checks    = 0;
    int failures  = 0;
    int txreq_cnt = 0;
    bit oe_seen   = 0;
    bit am_seen   = 0;

    logic [8:0] exp_rx[$];
    logic [7:0] exp_rd[$];

    i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .ref_clk(ref_clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .tx_data(tx_data), .tx_req(tx_req),
        .busy(busy), .addr_match(addr_match)
    );

    always #5 ref_clk = ~ref_clk;

    // Open-drain wired-AND of master and target.
    assign sda_in = sda_m & ~sda_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One system cycle; monitors DUT outputs away from the rising edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge ref_clk);
        if (sda_oe) oe_seen = 1'b1;
        if (addr_match) am_seen = 1'b1;
        if (tx_req) txreq_cnt++;
        if (rx_valid) begin
            chk("rx_valid_expected", (exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0) begin
                e = exp_rx.pop_front();
                chk("rx_first_data", {rx_first, rx_data}, e);
            end
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) tick();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q(1);
        scl_in = 1'b1; wait_q(1);
        sda_m = 1'b0; wait_q(1);
        scl_in = 1'b0; wait_q(1);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q(1);
        scl_in = 1'b1; wait_q(1);
        sda_m = 1'b1; wait_q(2);
    endtask

    task automatic bit_write(input logic b);
        sda_m = b; wait_q(1);
        scl_in = 1'b1; wait_q(2);
        scl_in = 1'b0; wait_q(1);
    endtask

    task automatic bit_read(output logic r);
        sda_m = 1'b1; wait_q(1);
        scl_in = 1'b1; wait_q(1);
        r = sda_in; wait_q(1);
        scl_in = 1'b0; wait_q(1);
    endtask

    // ack=1 when the target pulled SDA low in the ninth slot.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_write(b[i]);
        bit_read(r);
        ack = ~r;
    endtask

    task automatic write_data(input logic [7:0] b, input logic first, output logic ack);
        exp_rx.push_back({first, b});
        write_byte(b, ack);
    endtask

    task automatic read8(output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_read(r);
            d = {d[6:0], r};
        end
    endtask

    task automatic check_read(input string tag, input logic [7:0] d);
        logic [7:0] e;
        chk({tag, "_queued"}, (exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
            e = exp_rd.pop_front();
            chk(tag, d, e);
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

        reset = 1'b0; scl_in = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        repeat (5) tick();
        chk("reset_outputs", {sda_oe, rx_data, rx_valid, rx_first, tx_req, busy, addr_match}, 0);
        reset = 1'b1;
        repeat (10) tick();
        chk("idle_outputs", {sda_oe, rx_data, rx_valid, rx_first, tx_req, busy, addr_match}, 0);

        // Write 0x42: 0xA5, 0x3C.
        i2c_start();
        chk("busy_after_start", busy, 1);
        write_byte(8'h84, ack);
        chk("wr_addr_ack", ack, 1);
        chk("wr_addr_match", addr_match, 1);
        write_data(8'hA5, 1'b1, ack);
        chk("wr_data0_ack", ack, 1);
        write_data(8'h3C, 1'b0, ack);
        chk("wr_data1_ack", ack, 1);
        i2c_stop();
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_rx_all_seen", exp_rx.size(), 0);

        // Write 0x43: not addressed.
        oe_seen = 1'b0; am_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, ack);
        chk("other_addr_nack", ack, 0);
        write_byte(8'h55, ack);
        i2c_stop();
        chk("other_oe_never", oe_seen, 0);
        chk("other_am_never", am_seen, 0);
        chk("other_rx_none", exp_rx.size(), 0);

        // Read 0x42: 0x81 (ACK), 0x7E (NACK).
        txreq_cnt = 0;
        tx_data = 8'h81; exp_rd.push_back(8'h81);
        i2c_start();
        write_byte(8'h85, ack);
        chk("rd_addr_ack", ack, 1);
        read8(d);
        tx_data = 8'h7E; exp_rd.push_back(8'h7E);
        bit_write(1'b0);
        check_read("rd_byte0", d);
        read8(d);
        bit_write(1'b1);
        check_read("rd_byte1", d);
        wait_q(1);
        chk("rd_released_after_nack", sda_oe, 0);
        chk("rd_tx_req_pulses", txreq_cnt, 2);
        i2c_stop();
        chk("rd_busy_after_stop", busy, 0);

        // Write 0x11, repeated START, read 0xF0.
        i2c_start();
        write_byte(8'h84, ack);
        chk("rs_wr_addr_ack", ack, 1);
        write_data(8'h11, 1'b1, ack);
        chk("rs_wr_data_ack", ack, 1);
        chk("rs_am_before_rs", addr_match, 1);
        tx_data = 8'hF0; exp_rd.push_back(8'hF0);
        i2c_start();
        chk("rs_am_dropped", addr_match, 0);
        chk("rs_busy_held", busy, 1);
        write_byte(8'h85, ack);
        chk("rs_rd_addr_ack", ack, 1);
        chk("rs_am_reasserted", addr_match, 1);
        read8(d);
        bit_write(1'b1);
        check_read("rs_rd_byte", d);
        i2c_stop();
        chk("rs_rx_all_seen", exp_rx.size(), 0);

        // STOP after 4 bits of a data byte.
        i2c_start();
        write_byte(8'h84, ack);
        chk("part_addr_ack", ack, 1);
        bit_write(1'b1); bit_write(1'b0); bit_write(1'b1); bit_write(1'b0);
        i2c_stop();
        chk("part_idle_flags", {busy, sda_oe, addr_match}, 0);
        chk("part_rx_none", exp_rx.size(), 0);

        // Reset while the target drives SDA during a read.
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'h85, ack);
        chk("rst_rd_addr_ack", ack, 1);
        wait_q(1);
        chk("rst_oe_driving", sda_oe, 1);
        reset = 1'b0;
        tick();
        chk("rst_outputs", {sda_oe, rx_data, rx_valid, rx_first, tx_req, busy, addr_match}, 0);
        tick();
        reset = 1'b1;
        wait_q(1);
        i2c_stop();
        i2c_start();
        write_byte(8'h84, ack);
        chk("post_rst_addr_ack", ack, 1);
        write_data(8'h5A, 1'b1, ack);
        chk("post_rst_data_ack", ack, 1);
        i2c_stop();
        chk("post_rst_rx_all_seen", exp_rx.size(), 0);
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Receiving end of the I2C link whose master clock is generated from `ref_clk` at 100 kHz. This block is a 7-bit-address I2C target (slave). It oversamples SCL/SDA on `ref_clk`, detects START/STOP, and acknowledges its own address. It delivers written bytes to local logic and serves read bytes from local logic through a one-cycle request handshake. SDA is driven open-drain through an output-enable; SCL is input-only, with no clock stretching.

## Interface
- `ADDR`, 7'h42: target address compared against the first byte after START.
- `SYNC_STAGES`, 2: synchronizer flops on `scl_in`/`sda_in`; minimum 2.
- `ref_clk`  in  1: system clock (100 MHz); all logic is on its rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `scl_in`  in  1: raw SCL pin level.
- `sda_in`  in  1: raw SDA pin level.
- `sda_oe`  out  1: 1 pulls SDA low; 0 releases it.
- `rx_data`  out  8: last byte written by the master, MSB first on the wire.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` is updated.
- `rx_first`  out  1: qualifies `rx_valid`; 1 on the first data byte after an address match.
- `tx_data`  in  8: byte to return on a master read.
- `tx_req`  out  1: one-cycle pulse asking for the next `tx_data`.
- `busy`  out  1: 1 from START until STOP.
- `addr_match`  out  1: 1 from the address ACK until STOP or repeated START.

## Operation
- Sampling: `scl_in`/`sda_in` pass through `SYNC_STAGES` flops plus one history flop. Events are computed from the synchronized signals:
  - `scl_rise`: SCL 0→1.
  - `scl_fall`: SCL 1→0.
  - `start`: SDA 1→0 while SCL is 1.
  - `stop`: SDA 0→1 while SCL is 1.
- Bit counter: 0–8 (4 bits); bit 8 is the ACK slot.
- States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
  - IDLE: on `start` → ADDR, counter 0.
  - ADDR: shift SDA in on each `scl_rise`. After the 8th bit, compare `[7:1]` with `ADDR`.
    - Match → ADDR_ACK.
    - Mismatch → IGNORE.
  - ADDR_ACK: on the `scl_fall` that ends bit 8 of the address byte, set `sda_oe`=1. On the next `scl_fall`:
    - If R/W=0: release SDA → WR.
    - If R/W=1: load the shifter from `tx_data` and drive bit 7 → RD.
    - `tx_req` pulses on the `scl_rise` of the ACK bit.
  - WR: shift on `scl_rise`. After the 8th bit: `rx_data` ← shifter, `rx_valid` pulses, then → WR_ACK. `rx_first`=1 only for the first byte of the transfer.
  - WR_ACK: drive ACK for the 9th clock (same edges as ADDR_ACK), release on its falling edge, then → WR. The block ACKs every byte.
  - RD: on each `scl_fall`, drive `sda_oe` = ~shifter MSB, then shift. After the 8th falling edge, release SDA → RD_ACK.
  - RD_ACK: sample SDA on `scl_rise`.
    - 0 (ACK): pulse `tx_req`. On the next `scl_fall`, load `tx_data` and drive its bit 7 → RD.
    - 1 (NACK): → IGNORE with SDA released.
  - IGNORE: `sda_oe`=0; wait for `start` or `stop`.
- `start` in any state (repeated START): counter 0, `sda_oe`=0, `addr_match`=0 → ADDR.
- `stop` in any state: `sda_oe`=0, `addr_match`=0, `busy`=0 → IDLE. A `stop` in mid-byte discards the partial byte; no `rx_valid`.
- If `start` and `scl_rise` occur in the same cycle, `start` wins.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_first`=0, `tx_req`=0, `busy`=0, `addr_match`=0; state IDLE.
- Pin-to-event latency is `SYNC_STAGES`+1 cycles (3 cycles at default).
- `sda_oe` changes on the cycle after `scl_fall` is detected. Hold after the SCL low edge is therefore 4 cycles (40 ns at default).
- `rx_valid` is asserted on the cycle after the 8th `scl_rise` of a data byte.
- `tx_data` is sampled on the cycle after the next `scl_fall` following `tx_req`. Local logic gets at least half an SCL period (≥ 500 cycles at 100 kHz) to present it and must hold it for that cycle.
- `busy` rises on the cycle after `start` and falls on the cycle after `stop`.

## Test plan
- Write to 0x42 with bytes 0xA5, 0x3C, then STOP:
  - Address ACK and two data ACKs are seen low on SDA.
  - `rx_valid` pulses twice with `rx_data` 0xA5 (`rx_first`=1), then 0x3C (`rx_first`=0).
  - `busy` falls after STOP.
- Write to 0x43: `sda_oe` stays 0 for the whole transfer; no `rx_valid`; `addr_match`=0.
- Read from 0x42 with `tx_data` 0x81, then 0x7E; master ACKs the first byte and NACKs the second:
  - SDA carries 10000001 then 01111110.
  - `tx_req` pulses twice.
  - SDA is released after the NACK.
- Write 0x42 with byte 0x11, repeated START, read 0x42 with `tx_data`=0xF0:
  - `rx_valid` fires once with `rx_data`=0x11.
  - Read returns 0xF0.
  - `addr_match` drops at the repeated START and reasserts at the read address ACK.
- STOP after 4 bits of a data byte: no `rx_valid`; state returns to IDLE; `sda_oe`=0.
- `reset`=0 during a read while `sda_oe`=1: the next cycle `sda_oe`=0 and all outputs are at reset values. The following transfer to 0x42 works normally.
